// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer between the LSU and a single-port data RAM.
// Sub-word stores run as read-modify-write. Bad requests and RAM timeouts
// return an error response without issuing or completing a RAM write.
module mem_access_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iREQ_VALID,
  output logic              oREQ_READY,
  input  logic              iREQ_WR,
  input  logic [2:0]        iFUNC3,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic [31:0]       iWDATA,
  output logic              oRSP_VALID,
  output logic [31:0]       oRSP_RDATA,
  output logic              oRSP_ERR,
  output logic              oRAM_CE,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [31:0]       oRAM_DATA,
  input  logic [31:0]       iRAM_DATA,
  input  logic              iRAM_ACK
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state, stateNext;
  logic              errQ, errNext;
  logic              wrQ;
  logic [2:0]        func3Q;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wdataQ;
  logic [31:0]       rbuf;
  logic [TO_W-1:0]   toCnt;

  logic              accept;
  logic              reqIllegal;
  logic              reqMisaligned;
  logic              isSwReq;
  logic              ramActive;
  logic              timeoutHit;
  logic [31:0]       wordMerged;
  logic [31:0]       loadData;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;

  // Request decode and handshake; ready is gated by reset so nothing is taken while held
  assign oREQ_READY    = (state == IDLE) && iRST_N;
  assign accept        = iREQ_VALID && oREQ_READY;
  assign reqIllegal    = iREQ_WR ? (iFUNC3 > 3'd2) : ((iFUNC3 == 3'd3) || (iFUNC3 >= 3'd6));
  assign reqMisaligned = ((iFUNC3[1:0] == 2'b01) && iADDR[0]) ||
                         ((iFUNC3[1:0] == 2'b10) && (iADDR[1:0] != 2'b00));
  assign isSwReq       = iREQ_WR && (iFUNC3[1:0] == 2'b10);
  assign ramActive     = (state == READ) || (state == WRITE);
  assign timeoutHit    = (toCnt == TO_W'(TIMEOUT));

  // Outputs decoded from registered state; async reset forces IDLE so CE drops at once
  assign oRAM_CE    = ramActive;
  assign oRAM_WR    = (state == WRITE);
  assign oRAM_ADDR  = ramActive ? {addrQ[ADDR_W-1:2], 2'b00} : '0;
  assign oRAM_DATA  = (state == WRITE) ? wordMerged : '0;
  assign oRSP_VALID = (state == RESP);
  assign oRSP_ERR   = (state == RESP) && errQ;
  assign oRSP_RDATA = ((state == RESP) && !errQ && !wrQ) ? loadData : '0;

  // State and error flag register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      errQ  <= 1'b0;
    end else begin
      state <= stateNext;
      errQ  <= errNext;
    end
  end

  // Next-state logic; an ack in the timeout cycle still counts as success
  always_comb begin
    stateNext = state;
    errNext   = errQ;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reqIllegal || reqMisaligned) begin
            stateNext = RESP;
            errNext   = 1'b1;
          end else begin
            errNext   = 1'b0;
            stateNext = isSwReq ? WRITE : READ;
          end
        end
      end
      READ: begin
        if (iRAM_ACK) begin
          stateNext = wrQ ? WRITE : RESP;
        end else if (timeoutHit) begin
          stateNext = RESP;
          errNext   = 1'b1;
        end
      end
      WRITE: begin
        if (iRAM_ACK) begin
          stateNext = RESP;
        end else if (timeoutHit) begin
          stateNext = RESP;
          errNext   = 1'b1;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request latch, read buffer and per-phase timeout counter
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrQ    <= 1'b0;
      func3Q <= '0;
      addrQ  <= '0;
      wdataQ <= '0;
      rbuf   <= '0;
      toCnt  <= '0;
    end else begin
      if (accept) begin
        wrQ    <= iREQ_WR;
        func3Q <= iFUNC3;
        addrQ  <= iADDR;
        wdataQ <= iWDATA;
      end
      if ((state == READ) && iRAM_ACK) begin
        rbuf <= iRAM_DATA;
      end
      if (stateNext != state) begin
        toCnt <= '0;
      end else if (ramActive && !iRAM_ACK) begin
        toCnt <= toCnt + TO_W'(1);
      end
    end
  end

  // Store word: lane merge for SB/SH, full word for SW
  always_comb begin
    wordMerged = rbuf;
    case (func3Q[1:0])
      2'b00:   wordMerged[{addrQ[1:0], 3'b000} +: 8] = wdataQ[7:0];
      2'b01:   wordMerged[{addrQ[1], 4'b0000} +: 16] = wdataQ[15:0];
      default: wordMerged = wdataQ;
    endcase
  end

  // Load extract with sign or zero extension
  always_comb begin
    byteSel = rbuf[{addrQ[1:0], 3'b000} +: 8];
    halfSel = rbuf[{addrQ[1], 4'b0000} +: 16];
    case (func3Q)
      3'd0:    loadData = {{24{byteSel[7]}}, byteSel};
      3'd1:    loadData = {{16{halfSel[15]}}, halfSel};
      3'd2:    loadData = rbuf;
      3'd4:    loadData = {24'h0, byteSel};
      3'd5:    loadData = {16'h0, halfSel};
      default: loadData = '0;
    endcase
  end

endmodule
